// File: rtl/gcm_pkg.sv
// Shared types and constants for the control-phase sequencer:
// state encoding, phase index names and the default step map.
package gcm_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_e;

   localparam int PH_A = 0;
   localparam int PH_B = 1;
   localparam int PH_C = 2;
   localparam int PH_D = 3;
   localparam int PH_E = 4;

   // Entry s sits at bits [3*s +: 3]; step order A,E,B,E,C,D,D
   localparam logic [20:0] DEF_STEP_MAP = {3'(PH_D), 3'(PH_D), 3'(PH_C), 3'(PH_E),
                                           3'(PH_B), 3'(PH_E), 3'(PH_A)};

endpackage

// File: rtl/gcm_seq_if.sv
// Control/status bundle between the control unit and the phase sequencer.
// The step-mode signals exist only when GCM_SINGLE_STEP_EN is defined.
interface gcm_seq_if #(
   parameter int PHASE_W = 5,
   parameter int CNT_W   = 4
) ();
   logic               start_i;
   logic               stall_i;
   logic               halt_i;
`ifdef GCM_SINGLE_STEP_EN
   logic               step_mode_i;
   logic               step_i;
`endif
   logic [PHASE_W-1:0] phase_o;
   logic [CNT_W-1:0]   step_o;
   logic               cycle_done_o;
   logic               busy_o;

   modport master (
      output start_i, stall_i, halt_i,
`ifdef GCM_SINGLE_STEP_EN
      output step_mode_i, step_i,
`endif
      input  phase_o, step_o, cycle_done_o, busy_o
   );

   modport slave (
      input  start_i, stall_i, halt_i,
`ifdef GCM_SINGLE_STEP_EN
      input  step_mode_i, step_i,
`endif
      output phase_o, step_o, cycle_done_o, busy_o
   );
endinterface

// File: rtl/gcm_onehot_dec.sv
// Combinational index to one-hot decoder; indices >= PHASE_W decode to zero.
module gcm_onehot_dec #(
   parameter int IDX_W   = 3,
   parameter int PHASE_W = 5
) (
   input  logic [IDX_W-1:0]   idx_i,
   output logic [PHASE_W-1:0] onehot_o
);
   always_comb begin
      onehot_o = '0;
      for (int i = 0; i < PHASE_W; i++) begin
         if (idx_i == IDX_W'(i)) onehot_o[i] = 1'b1;
      end
   end
endmodule

// File: rtl/gcm_seq.sv
// Parametrised control-phase sequencer: step counter, IDLE/RUN/DRAIN FSM, registered one-hot phase.
// Optional single-step control is compiled in with the GCM_SINGLE_STEP_EN macro.
module gcm_seq
   import gcm_pkg::*;
#(
   parameter int                       N_STEPS  = 7,
   parameter int                       CNT_W    = 4,
   parameter int                       PHASE_W  = 5,
   parameter int                       IDX_W    = 3,
   parameter logic [N_STEPS*IDX_W-1:0] STEP_MAP = DEF_STEP_MAP
) (
   input logic      clk,
   input logic      rst_i,
   gcm_seq_if.slave bus
);

   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(N_STEPS - 1);

   generate
      if (N_STEPS < 2 || N_STEPS > (1 << CNT_W)) begin : g_bad_steps
         $error("gcm_seq: N_STEPS out of range for CNT_W");
      end
      for (genvar s = 0; s < N_STEPS; s++) begin : g_map_chk
         if (int'(STEP_MAP[s*IDX_W +: IDX_W]) >= PHASE_W) begin : g_bad_entry
            $error("gcm_seq: STEP_MAP entry exceeds PHASE_W");
         end
      end
   endgenerate

   function automatic logic [IDX_W-1:0] map_idx(input logic [CNT_W-1:0] s);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_STEPS; i++) begin
         if (s == CNT_W'(i)) idx = STEP_MAP[i*IDX_W +: IDX_W];
      end
      return idx;
   endfunction

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   step_q, step_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic               pend_q, pend_d;
   logic [IDX_W-1:0]   dec_idx;
   logic [PHASE_W-1:0] dec_phase;
   logic               adv;
   logic               halt_eff;
   logic               at_last;

`ifdef GCM_SINGLE_STEP_EN
   assign adv = !bus.stall_i && (!bus.step_mode_i || bus.step_i);
`else
   assign adv = !bus.stall_i;
`endif

   // A halt seen during a stall is remembered until the next advancing edge
   assign halt_eff = bus.halt_i | pend_q;
   assign at_last  = (step_q == LAST_STEP);

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      pend_d  = pend_q;
      unique case (state_q)
         IDLE: begin
            pend_d = 1'b0;
            if (bus.start_i && !bus.halt_i) begin
               state_d = RUN;
               step_d  = '0;
            end
         end
         RUN: begin
            if (adv) begin
               pend_d = 1'b0;
               if (halt_eff && at_last) begin
                  state_d = IDLE;
                  step_d  = '0;
               end else begin
                  step_d = at_last ? '0 : step_q + CNT_W'(1);
                  if (halt_eff) state_d = DRAIN;
               end
            end else begin
               pend_d = halt_eff;
            end
         end
         DRAIN: begin
            pend_d = 1'b0;
            if (adv) begin
               if (at_last) begin
                  state_d = IDLE;
                  step_d  = '0;
               end else begin
                  step_d = step_q + CNT_W'(1);
               end
            end
         end
         default: begin
            state_d = IDLE;
            step_d  = '0;
            pend_d  = 1'b0;
         end
      endcase
   end

   // Phase is decoded from the next step so it registers alongside step_q
   assign dec_idx = map_idx(step_d);

   gcm_onehot_dec #(
      .IDX_W   (IDX_W),
      .PHASE_W (PHASE_W)
   ) u_dec (
      .idx_i    (dec_idx),
      .onehot_o (dec_phase)
   );

   assign phase_d = (state_d != IDLE) ? dec_phase : '0;

   always_ff @(posedge clk or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         step_q  <= '0;
         phase_q <= '0;
         pend_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         phase_q <= phase_d;
         pend_q  <= pend_d;
      end
   end

   assign bus.phase_o      = phase_q;
   assign bus.step_o       = step_q;
   assign bus.busy_o       = (state_q != IDLE);
   assign bus.cycle_done_o = (state_q != IDLE) && at_last;

endmodule

// File: tb/tb_gcm_seq.sv
// Self-checking bench for gcm_seq: default 7-step map instance plus a 4-step map instance.
module tb_gcm_seq;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   gcm_seq_if #(.PHASE_W(5), .CNT_W(4)) bus_a ();
   gcm_seq_if #(.PHASE_W(5), .CNT_W(4)) bus_b ();

   gcm_seq u_a (
      .clk   (clk),
      .rst_i (rst),
      .bus   (bus_a)
   );

   gcm_seq #(
      .N_STEPS  (4),
      .CNT_W    (4),
      .PHASE_W  (5),
      .IDX_W    (3),
      .STEP_MAP ({3'd2, 3'd1, 3'd1, 3'd0})
   ) u_b (
      .clk   (clk),
      .rst_i (rst),
      .bus   (bus_b)
   );

   int total = 0;
   int bad   = 0;
   logic [10:0] sbq[$];

   logic [4:0] pha [7] = '{5'b00001, 5'b10000, 5'b00010, 5'b10000, 5'b00100, 5'b01000, 5'b01000};
   logic [4:0] phb [4] = '{5'b00001, 5'b00010, 5'b00010, 5'b00100};

   // Packed view: {step[3:0], phase[4:0], cycle_done, busy}
   function automatic logic [10:0] pk(input int s, input logic [4:0] p, input logic cd, input logic b);
      return {4'(s), p, cd, b};
   endfunction

   task automatic drive_idle();
      bus_a.start_i = 1'b0; bus_a.stall_i = 1'b0; bus_a.halt_i = 1'b0;
      bus_b.start_i = 1'b0; bus_b.stall_i = 1'b0; bus_b.halt_i = 1'b0;
`ifdef GCM_SINGLE_STEP_EN
      bus_a.step_mode_i = 1'b0; bus_a.step_i = 1'b0;
      bus_b.step_mode_i = 1'b0; bus_b.step_i = 1'b0;
`endif
   endtask

   // Reset pulse then start bus_a; returns #1 after the edge that enters step 0
   task automatic restart();
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      @(negedge clk);
      rst = 1'b0;
      bus_a.start_i = 1'b1;
      @(posedge clk);
      #1;
      bus_a.start_i = 1'b0;
   endtask

   task automatic test_reset();
      logic [10:0] g;
      rst = 1'b1;
      bus_a.start_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      g = {bus_a.step_o, bus_a.phase_o, bus_a.cycle_done_o, bus_a.busy_o};
      total++;
      if (g !== 11'd0) begin
         bad++;
         $display("FAIL reset_state got=%b exp=%b", g, 11'd0);
      end
      @(negedge clk);
      rst = 1'b0;
      bus_a.start_i = 1'b0;
   endtask

   task automatic test_run();
      logic [10:0] e, g;
      for (int k = 0; k < 14; k++) begin
         bus_a.start_i = (k == 0 || k == 3);
         sbq.push_back(pk(k % 7, pha[k % 7], (k % 7) == 6, 1'b1));
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         g = {bus_a.step_o, bus_a.phase_o, bus_a.cycle_done_o, bus_a.busy_o};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL run k=%0d got=%b exp=%b", k, g, e);
         end
      end
      bus_a.start_i = 1'b0;
   endtask

   task automatic test_stall();
      int stl [10] = '{0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
      int es  [10] = '{1, 2, 2, 2, 2, 3, 4, 5, 6, 0};
      logic [10:0] e, g;
      restart();
      for (int i = 0; i < 10; i++) begin
         bus_a.stall_i = stl[i][0];
         sbq.push_back(pk(es[i], pha[es[i]], es[i] == 6, 1'b1));
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         g = {bus_a.step_o, bus_a.phase_o, bus_a.cycle_done_o, bus_a.busy_o};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL stall i=%0d got=%b exp=%b", i, g, e);
         end
      end
      bus_a.stall_i = 1'b0;
   endtask

   task automatic test_halt();
      int rs [24] = '{0,0,0,0,0,0,0,0, 0, 1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0};
      int sa [24] = '{0,0,0,0,0,0,0,0, 1, 0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0};
      int st [24] = '{0,0,0,0,0,0,0,0, 0, 0,0,0,0,0,0,0, 0,1,0,0,0,0,0,0};
      int ha [24] = '{0,1,0,0,0,0,0,0, 1, 0,0,0,0,0,0,1, 0,1,0,0,0,0,0,0};
      int es [24] = '{1,2,3,4,5,6,-1,-1, -1, 1,2,3,4,5,6,-1, 1,1,2,3,4,5,6,-1};
      logic [10:0] e, g;
      restart();
      for (int i = 0; i < 24; i++) begin
         if (rs[i] != 0) restart();
         bus_a.start_i = sa[i][0];
         bus_a.stall_i = st[i][0];
         bus_a.halt_i  = ha[i][0];
         if (es[i] < 0) sbq.push_back(11'd0);
         else           sbq.push_back(pk(es[i], pha[es[i]], es[i] == 6, 1'b1));
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         g = {bus_a.step_o, bus_a.phase_o, bus_a.cycle_done_o, bus_a.busy_o};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL halt i=%0d got=%b exp=%b", i, g, e);
         end
      end
      drive_idle();
   endtask

   task automatic test_async_reset();
      logic [10:0] e, g;
      restart();
      for (int k = 1; k < 5; k++) begin
         sbq.push_back(pk(k, pha[k], 1'b0, 1'b1));
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         g = {bus_a.step_o, bus_a.phase_o, bus_a.cycle_done_o, bus_a.busy_o};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL async_pre k=%0d got=%b exp=%b", k, g, e);
         end
      end
      #3;
      rst = 1'b1;
      #1;
      g = {bus_a.step_o, bus_a.phase_o, bus_a.cycle_done_o, bus_a.busy_o};
      total++;
      if (g !== 11'd0) begin
         bad++;
         $display("FAIL async_clear got=%b exp=%b", g, 11'd0);
      end
      #2;
      rst = 1'b0;
      for (int k = 0; k < 2; k++) begin
         bus_a.start_i = (k == 0);
         sbq.push_back(pk(k, pha[k], 1'b0, 1'b1));
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         g = {bus_a.step_o, bus_a.phase_o, bus_a.cycle_done_o, bus_a.busy_o};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL async_restart k=%0d got=%b exp=%b", k, g, e);
         end
      end
      bus_a.start_i = 1'b0;
   endtask

   task automatic test_short_map();
      logic [10:0] e, g;
      @(negedge clk);
      rst = 1'b1;
      drive_idle();
      @(negedge clk);
      rst = 1'b0;
      for (int k = 0; k < 9; k++) begin
         bus_b.start_i = (k == 0);
         sbq.push_back(pk(k % 4, phb[k % 4], (k % 4) == 3, 1'b1));
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         g = {bus_b.step_o, bus_b.phase_o, bus_b.cycle_done_o, bus_b.busy_o};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL short_map k=%0d got=%b exp=%b", k, g, e);
         end
      end
      bus_b.start_i = 1'b0;
   endtask

`ifdef GCM_SINGLE_STEP_EN
   task automatic test_single_step();
      int md  [8] = '{1, 1, 1, 1, 1, 1, 0, 0};
      int stp [8] = '{0, 1, 1, 0, 1, 1, 0, 0};
      int stl [8] = '{0, 0, 0, 0, 1, 0, 0, 0};
      int es  [8] = '{0, 1, 2, 2, 2, 3, 4, 5};
      logic [10:0] e, g;
      restart();
      for (int i = 0; i < 8; i++) begin
         bus_a.step_mode_i = md[i][0];
         bus_a.step_i      = stp[i][0];
         bus_a.stall_i     = stl[i][0];
         sbq.push_back(pk(es[i], pha[es[i]], es[i] == 6, 1'b1));
         @(posedge clk);
         #1;
         e = sbq.pop_front();
         g = {bus_a.step_o, bus_a.phase_o, bus_a.cycle_done_o, bus_a.busy_o};
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL single_step i=%0d got=%b exp=%b", i, g, e);
         end
      end
      drive_idle();
   endtask
`endif

   initial begin
      drive_idle();
      test_reset();
      test_run();
      test_stall();
      test_halt();
      test_async_reset();
      test_short_map();
`ifdef GCM_SINGLE_STEP_EN
      test_single_step();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
